dmem_copy_engine: RTL and testbench
===================================

Name: dmem_copy_engine

Overview:
- Memory-side initiator for the single-port data memory (`data_mem`).
- Drives the `mem_read`/`mem_write`/`addr`/`write_data` pins of `data_mem` and consumes its `read_data`.
- Copies a block of 32-bit words from a source byte address to a destination byte address, one word at a time, under a start/busy/done handshake.
- Sits between the CPU control path (or a testbench) and `data_mem`, so memory can be initialised or relocated without the CPU datapath.

Parameters:
- LEN_W, 8, width of the word-count input (max block of 2^LEN_W-1 words).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  32  source byte address; must be word-aligned (bits [1:0]=0).
- dst_addr  input  32  destination byte address; must be word-aligned.
- length  input  LEN_W  number of words to copy.
- busy  output  1  high from the cycle after an accepted start until the cycle DONE is entered.
- done  output  1  one-cycle pulse at completion.
- err  output  1  sticky misalignment flag; cleared by the next accepted start.
- mem_read  output  1  to `data_mem.mem_read`.
- mem_write  output  1  to `data_mem.mem_write`.
- addr  output  32  to `data_mem.addr` (byte address).
- write_data  output  32  to `data_mem.write_data`.
- read_data  input  32  from `data_mem.read_data`; combinational read (valid in the same cycle `addr`/`mem_read` are presented); `data_mem` writes on the posedge while `mem_write`=1.

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, err, mem_read, mem_write = 0. addr, write_data = 0. Internal src_ptr, dst_ptr, cnt, buf = 0.
- A reset mid-copy aborts immediately. Words already written stay written; no done pulse.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - All memory controls 0.
  - On start: latch src_ptr=src_addr, dst_ptr=dst_addr, cnt=length; clear err.
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0: set err=1, go FIN (no memory access).
  - Else if length==0: go FIN.
  - Else go RD.
- RD:
  - mem_read=1, mem_write=0, addr=src_ptr.
  - At posedge: buf<=read_data, go WR.
- WR:
  - mem_write=1, mem_read=0, addr=dst_ptr, write_data=buf.
  - At posedge: src_ptr+=4, dst_ptr+=4, cnt-=1.
  - If cnt==1 (last word) go FIN, else go RD.
- FIN: done=1 for exactly this one cycle, busy=0, memory controls 0. Next state IDLE.
- Timing:
  - busy=1 in every RD/WR cycle.
  - Latency from the start cycle to done: 2*length+1 cycles, or 1 cycle for length 0 or misalignment.
- start while not in IDLE is ignored; it is not queued.
- mem_read and mem_write are never high in the same cycle.
- Outputs are decoded from state and registers only; no combinational path from start to mem pins.
- Address arithmetic is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000 without error.
- Overlap: strictly ascending word-by-word copy. With dst>src and overlapping regions the result is a propagating pattern; this is defined behaviour, not an error.
- A write to a word read later in the same block is seen by that later read, since `data_mem` writes at the WR posedge.

Test Plan:
1. Preload `data_mem` words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444. Start src=0x0, dst=0x40, len=4 -> words 16..19 equal those values; done exactly 9 cycles after start; busy high for 8 cycles.
2. Start with len=0 -> done pulse on the next cycle; mem_read and mem_write never asserted; memory unchanged.
3. Start with src=0x2, dst=0x40, len=3 -> err=1, done after 1 cycle, no memory access. A following valid start (src=0, dst=0x80, len=1) clears err and copies 0x11111111 into word 32.
4. Overlapping copy, src=0x0, dst=0x4, len=3, words 0..3 = A,B,C,D -> words 1..3 all equal A.
5. Assert rst after 3 cycles of a len=8 copy -> all outputs 0 immediately; state IDLE; at most one word written; no done. A new start then completes normally.
6. Pulse start again during busy of a len=2 copy -> ignored; exactly one done pulse; only 2 writes observed.

Source files
------------

// File: rtl/dmem_copy_engine_if.sv
// dmem_copy_engine_if: groups the copy-engine control handshake and the
// data_mem pin bundle.
//   slave  : the copy engine. It takes the start request and read_data, and
//            drives the status outputs and the memory pins.
//   master : the controller / memory side (CPU control path or bench).
// Signals:
//   start, src_addr, dst_addr, length : copy request
//   busy, done, err                   : status
//   mem_read, mem_write, addr,
//   write_data, read_data             : data_mem pins
interface dmem_copy_engine_if #(parameter int LEN_W = 8);
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             done;
  logic             err;
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      addr;
  logic [31:0]      write_data;
  logic [31:0]      read_data;

  modport slave (
    input  start, src_addr, dst_addr, length, read_data,
    output busy, done, err, mem_read, mem_write, addr, write_data
  );

  modport master (
    output start, src_addr, dst_addr, length, read_data,
    input  busy, done, err, mem_read, mem_write, addr, write_data
  );
endinterface

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: copies a block of 32-bit words from src_addr to dst_addr
// in data_mem. Each word takes two cycles, an RD cycle followed by a WR
// cycle, and words are copied in ascending order.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : dmem_copy_engine_if.slave
//         - start/src_addr/dst_addr/length in
//         - busy/done/err out
//         - data_mem pins
// All outputs are registered. They are loaded on the transition into the
// state that presents them, so start has no combinational path to the
// memory pins.
module dmem_copy_engine #(
  parameter int LEN_W = 8
) (
  input logic            clk,
  input logic            rst,
  dmem_copy_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  typedef struct packed {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] cnt;
  } xfer_t;

  state_t      state;
  xfer_t       xf;
  logic        busy_q, done_q, err_q, rd_q, wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;  // doubles as the word buffer between RD and WR

  wire misal = (bus.src_addr[1:0] != 2'b00) || (bus.dst_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      xf      <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            xf    <= '{src: bus.src_addr, dst: bus.dst_addr, cnt: bus.length};
            err_q <= misal;
            if (misal || bus.length == '0) begin
              done_q <= 1'b1;
              state  <= FIN;
            end else begin
              busy_q <= 1'b1;
              rd_q   <= 1'b1;
              addr_q <= bus.src_addr;
              state  <= RD;
            end
          end
        end
        RD: begin
          wdata_q <= bus.read_data;
          rd_q    <= 1'b0;
          wr_q    <= 1'b1;
          addr_q  <= xf.dst;
          state   <= WR;
        end
        WR: begin
          wr_q   <= 1'b0;
          xf.src <= xf.src + 32'd4;
          xf.dst <= xf.dst + 32'd4;
          xf.cnt <= xf.cnt - LEN_W'(1);
          if (xf.cnt == LEN_W'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            addr_q <= '0;
            state  <= FIN;
          end else begin
            rd_q   <= 1'b1;
            addr_q <= xf.src + 32'd4;  // next source word, ahead of the pointer update
            state  <= RD;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.mem_read   = rd_q;
  assign bus.mem_write  = wr_q;
  assign bus.addr       = addr_q;
  assign bus.write_data = wdata_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
module tb_dmem_copy_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_copy_engine_if #(.LEN_W(8)) bus ();
  dmem_copy_engine #(.LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // 256-word data_mem model: combinational read, addresses alias mod 1 KiB
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  assign bus.read_data = mem[bus.addr[9:2]];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int pass  = 0;
  int total = 0;

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  // Reference copy: ascending word order, applied to ref_mem so that
  // overlapping copies propagate as the hardware should.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n);
    logic [31:0] sa, da;
    wr_t w;
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) return;
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      ref_mem[da[9:2]] = ref_mem[sa[9:2]];
      w.a = da;
      w.d = ref_mem[da[9:2]];
      exp_q.push_back(w);
    end
  endtask

  // Drives one request and monitors the bus until done. The data_mem
  // write is applied at the negedge of each WR cycle; nothing reads it
  // before the following RD cycle.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                          input int pulse_at, output int lat, output int bsy,
                          output int nrd, output int nwr, output bit both);
    int cyc;
    wr_t w;
    lat = -1; bsy = 0; nrd = 0; nwr = 0; both = 1'b0; cyc = 0;
    model_copy(s, d, n);
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.length = n;
    @(posedge clk);
    #1 bus.start = 1'b0;
    while (lat < 0) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.busy) bsy++;
      if (bus.mem_read) nrd++;
      if (bus.mem_read && bus.mem_write) both = 1'b1;
      if (bus.mem_write) begin
        nwr++;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_write: unexpected write addr %h data %h", bus.addr, bus.write_data);
        end else begin
          w = exp_q.pop_front();
          if (bus.addr !== w.a || bus.write_data !== w.d)
            $display("FAIL sb_write: got addr %h data %h exp addr %h data %h",
                     bus.addr, bus.write_data, w.a, w.d);
          else pass++;
        end
        mem[bus.addr[9:2]] = bus.write_data;
      end
      if (bus.done) lat = cyc;
      else if (cyc > 600) begin
        total++;
        $display("FAIL timeout: no done after %0d cycles (exp none)", cyc);
        lat = 0;
      end
      if (cyc == pulse_at) begin
        bus.start = 1'b1; bus.src_addr = 32'h0; bus.dst_addr = 32'h3F0; bus.length = 8'd5;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    total++;
    if ({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write} !== 5'b0)
      $display("FAIL reset_ctl: got %b exp 00000",
               {bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write});
    else pass++;
    total++;
    if (bus.addr !== 32'h0) $display("FAIL reset_addr: got %h exp 0", bus.addr); else pass++;
    total++;
    if (bus.write_data !== 32'h0) $display("FAIL reset_wdata: got %h exp 0", bus.write_data); else pass++;
  endtask

  task automatic test_mem(input string nm);
    int bad;
    bad = -1;
    for (int i = 255; i >= 0; i--) if (mem[i] !== ref_mem[i]) bad = i;
    total++;
    if (bad >= 0) $display("FAIL %s_mem: word %0d got %h exp %h", nm, bad, mem[bad], ref_mem[bad]);
    else pass++;
  endtask

  task automatic test_basic();
    int lat, bsy, nrd, nwr; bit both;
    logic [31:0] expv [4];
    expv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) set_word(i, expv[i]);
    run_copy(32'h0, 32'h40, 8'd4, -1, lat, bsy, nrd, nwr, both);
    total++; if (lat !== 9) $display("FAIL basic_latency: got %0d exp 9", lat); else pass++;
    total++; if (bsy !== 8) $display("FAIL basic_busy: got %0d exp 8", bsy); else pass++;
    total++; if (nwr !== 4 || nrd !== 4) $display("FAIL basic_count: got rd %0d wr %0d exp 4 4", nrd, nwr); else pass++;
    total++; if (both) $display("FAIL basic_rdwr_excl: got 1 exp 0"); else pass++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[16+i] !== expv[i]) $display("FAIL basic_word%0d: got %h exp %h", 16+i, mem[16+i], expv[i]);
      else pass++;
    end
    test_mem("basic");
  endtask

  task automatic test_len0();
    int lat, bsy, nrd, nwr; bit both;
    run_copy(32'h0, 32'h80, 8'd0, -1, lat, bsy, nrd, nwr, both);
    total++; if (lat !== 1) $display("FAIL len0_latency: got %0d exp 1", lat); else pass++;
    total++; if (nrd + nwr + bsy !== 0) $display("FAIL len0_access: got rd %0d wr %0d busy %0d exp 0", nrd, nwr, bsy); else pass++;
    test_mem("len0");
  endtask

  task automatic test_misalign();
    int lat, bsy, nrd, nwr; bit both;
    run_copy(32'h2, 32'h40, 8'd3, -1, lat, bsy, nrd, nwr, both);
    total++; if (lat !== 1) $display("FAIL misal_latency: got %0d exp 1", lat); else pass++;
    total++; if (bus.err !== 1'b1) $display("FAIL misal_err: got %b exp 1", bus.err); else pass++;
    total++; if (nrd + nwr !== 0) $display("FAIL misal_access: got %0d exp 0", nrd + nwr); else pass++;
    @(negedge clk);
    total++; if (bus.err !== 1'b1) $display("FAIL misal_sticky: got %b exp 1", bus.err); else pass++;
    run_copy(32'h0, 32'h80, 8'd1, -1, lat, bsy, nrd, nwr, both);
    total++; if (bus.err !== 1'b0) $display("FAIL misal_clear: got %b exp 0", bus.err); else pass++;
    total++; if (lat !== 3) $display("FAIL misal_next_lat: got %0d exp 3", lat); else pass++;
    total++; if (mem[32] !== 32'h11111111) $display("FAIL misal_word32: got %h exp 11111111", mem[32]); else pass++;
  endtask

  task automatic test_overlap();
    int lat, bsy, nrd, nwr; bit both;
    set_word(0, 32'hAAAA0000); set_word(1, 32'hBBBB1111);
    set_word(2, 32'hCCCC2222); set_word(3, 32'hDDDD3333);
    run_copy(32'h0, 32'h4, 8'd3, -1, lat, bsy, nrd, nwr, both);
    total++; if (lat !== 7) $display("FAIL overlap_latency: got %0d exp 7", lat); else pass++;
    for (int i = 1; i < 4; i++) begin
      total++;
      if (mem[i] !== 32'hAAAA0000) $display("FAIL overlap_word%0d: got %h exp aaaa0000", i, mem[i]);
      else pass++;
    end
  endtask

  task automatic test_wrap();
    int lat, bsy, nrd, nwr; bit both;
    set_word(254, 32'hFEFE0001); set_word(255, 32'hFFFF0002);
    run_copy(32'hFFFF_FFF8, 32'h100, 8'd3, -1, lat, bsy, nrd, nwr, both);
    total++; if (bus.err !== 1'b0) $display("FAIL wrap_src_err: got %b exp 0", bus.err); else pass++;
    test_mem("wrap_src");
    run_copy(32'h100, 32'hFFFF_FFFC, 8'd2, -1, lat, bsy, nrd, nwr, both);
    test_mem("wrap_dst");
  endtask

  task automatic test_abort();
    int nwr, ndone, lat, bsy, nrd; bit both;
    nwr = 0; ndone = 0;
    for (int i = 0; i < 8; i++) set_word(128 + i, 32'h5A00_0000 + 32'(i));
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = 32'h200; bus.dst_addr = 32'h300; bus.length = 8'd8;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.mem_write) begin
        nwr++;
        mem[bus.addr[9:2]] = bus.write_data;
      end
    end
    ref_mem[192] = 32'h5A00_0000;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write} !== 5'b0 || bus.addr !== 32'h0 || bus.write_data !== 32'h0)
      $display("FAIL abort_outputs: got ctl %b addr %h wdata %h exp 0", {bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write}, bus.addr, bus.write_data);
    else pass++;
    total++; if (nwr !== 1 || ndone !== 0) $display("FAIL abort_writes: got wr %0d done %0d exp 1 0", nwr, ndone); else pass++;
    @(negedge clk);
    rst = 1'b0;
    test_mem("abort");
    run_copy(32'h200, 32'h380, 8'd2, -1, lat, bsy, nrd, nwr, both);
    total++; if (lat !== 5) $display("FAIL abort_recover_lat: got %0d exp 5", lat); else pass++;
    test_mem("abort_recover");
  endtask

  task automatic test_back_to_back();
    int lat, bsy, nrd, nwr, extra; bit both;
    extra = 0;
    run_copy(32'h40, 32'hC0, 8'd2, 2, lat, bsy, nrd, nwr, both);
    total++; if (lat !== 5) $display("FAIL b2b_latency: got %0d exp 5", lat); else pass++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done || bus.mem_write || bus.mem_read || bus.busy) extra++;
    end
    total++; if (nwr !== 2 || extra !== 0) $display("FAIL b2b_ignored: got wr %0d extra %0d exp 2 0", nwr, extra); else pass++;
    test_mem("b2b");
  endtask

  initial begin
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    for (int i = 0; i < 256; i++) set_word(i, 32'hC0DE_0000 + 32'(i));
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_len0();
    test_misalign();
    test_overlap();
    test_wrap();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
